calc_display_driver: RTL

//  Display end of the calculator's digit-output interface: receives per-digit writes
//  (data, position) plus the calculator status word, holds them in a digit buffer,
//  and drives a time-multiplexed, active-low 7-segment display.

---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_display_driver_seg7_decoder.sv | 33 +++
 rtl/calc_display_driver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: glyph codes, status word, digit-write request.
package calc_pkg;

  localparam logic [3:0] GLYPH_PLUS  = 4'd10;
  localparam logic [3:0] GLYPH_MINUS = 4'd11;
  localparam logic [3:0] GLYPH_STAR  = 4'd12;
  localparam logic [3:0] GLYPH_BLANK = 4'd13;
  localparam logic [3:0] GLYPH_EQ    = 4'd14;
  localparam logic [3:0] GLYPH_E     = 4'd15;

  // position value that, together with wr, blanks the whole buffer
  localparam logic [3:0] POS_CLEAR = 4'hF;

  // segments {g,f,e,d,c,b,a}, active-low, all dark
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_RESULT = 2'b10,
    ST_ERROR  = 2'b11
  } status_t;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] pos;
    logic [3:0] data;
  } dig_wr_t;

endpackage

// File: rtl/calc_display_driver_seg7_decoder.sv
// Glyph code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg
);

  // full 16-entry table, every code has a defined pattern
  always_comb begin
    seg = SEG_OFF;
    case (glyph)
      4'd0:        seg = 7'h40;
      4'd1:        seg = 7'h79;
      4'd2:        seg = 7'h24;
      4'd3:        seg = 7'h30;
      4'd4:        seg = 7'h19;
      4'd5:        seg = 7'h12;
      4'd6:        seg = 7'h02;
      4'd7:        seg = 7'h78;
      4'd8:        seg = 7'h00;
      4'd9:        seg = 7'h10;
      GLYPH_PLUS:  seg = 7'h39;  // b,c,g
      GLYPH_MINUS: seg = 7'h3F;  // g
      GLYPH_STAR:  seg = 7'h1C;  // a,b,f,g (raised box)
      GLYPH_BLANK: seg = SEG_OFF;
      GLYPH_EQ:    seg = 7'h37;  // d,g
      GLYPH_E:     seg = 7'h06;  // a,d,e,f,g
      default:     seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/calc_display_driver.sv
// Digit buffer plus time-multiplexed active-low 7-segment scan driver.
// Each slot starts with a short all-anodes-off guard to avoid ghosting.
module calc_display_driver
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 16,
  parameter int BLINK_DIV    = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [3:0]            data,
  input  logic [3:0]            position,
  input  logic [1:0]            status,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

  logic [NUM_DIGITS-1:0][3:0] dbuf;
  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  logic [BLINK_DIV:0]         blink_cnt;
  scan_state_t                state_q, state_d;
  dig_wr_t                    req;
  status_t                    st;
  logic [6:0]                 seg_cur;
  logic [NUM_DIGITS-1:0]      an_d;
  logic [6:0]                 seg_d;
  logic                       dp_d;
  logic                       blink_on;

  assign req      = '{vld: wr, pos: position, data: data};
  assign st       = status_t'(status);
  assign blink_on = blink_cnt[BLINK_DIV];

  // digit buffer: single-entry write or clear-all; out-of-range positions dropped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbuf <= {NUM_DIGITS{GLYPH_BLANK}};
    end else if (req.vld) begin
      if (req.pos == POS_CLEAR) begin
        dbuf <= {NUM_DIGITS{GLYPH_BLANK}};
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (req.pos == 4'(i)) dbuf[i] <= req.data;
      end
    end
  end

  // slot counter spans guard+on; digit index advances when the slot wraps
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // scan state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_GUARD;
    else        state_q <= state_d;
  end

  // scan next-state: guard ends after GUARD_CYCLES, on-phase ends at slot end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GUARD: if (cnt == GUARD_LAST) state_d = S_ON;
      S_ON:    if (cnt == CNT_LAST)   state_d = S_GUARD;
      default: state_d = S_GUARD;
    endcase
  end

  seg7_decoder u_dec (
    .glyph (dbuf[idx]),
    .seg   (seg_cur)
  );

  // next output values: enable current digit, error blink blanks anodes, busy lights dp0
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == S_ON) begin
      seg_d = seg_cur;
      if (!(st == ST_ERROR && blink_on)) begin
        an_d = ~(NUM_DIGITS'(1) << idx);
        if (st == ST_BUSY && idx == '0) dp_d = 1'b0;
      end
    end
  end

  // registered pin drivers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
